// File: rtl/pingpong_ram_pkg.sv
// pingpong_ram_pkg
// Shared constants and types for the ping-pong frame store.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths
//   NUM_BANKS               : number of frame banks (fixed at two)
//   bank_sel_t              : bank index type
//   other_bank()            : returns the opposite bank index
package pingpong_ram_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 7;
    localparam int NUM_BANKS  = 2;

    typedef logic bank_sel_t;

    function automatic bank_sel_t other_bank(input bank_sel_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/pingpong_ram_bank.sv
// pingpong_ram_bank
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
// The array itself is never reset; only the read register is.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (read register only)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address, sampled every cycle
//   rdata_o  : registered read data, one-cycle latency
module pingpong_ram_bank
    import pingpong_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking read of the array gives read-before-write on collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_ram.sv
// pingpong_ram
// Double-buffered frame store. The producer (port A) fills one bank while the
// consumer (port B) drains the other; banks change hands only on the finish
// strobes. Optional sticky error flags are built when PINGPONG_RAM_ERR_EN is
// defined.
//   clk      : single clock, rising edge
//   rst      : asynchronous active-high reset
//   addra    : write address within current write bank
//   wea      : write enable (ignored while readya=0)
//   dina     : write data
//   finisha  : commit current write bank to the reader (ignored while readya=0)
//   addrb    : read address within current read bank
//   finishb  : release current read bank (ignored while readyb=0)
//   readya   : current write bank is free
//   doutb    : registered read data, one-cycle latency
//   readyb   : current read bank holds a completed frame
//   err_wr   : (PINGPONG_RAM_ERR_EN) sticky, wea/finisha seen while readya=0
//   err_rd   : (PINGPONG_RAM_ERR_EN) sticky, finishb seen while readyb=0
module pingpong_ram
    import pingpong_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addra,
    input  logic              wea,
    input  logic [DATA_W-1:0] dina,
    input  logic              finisha,
    input  logic [ADDR_W-1:0] addrb,
    input  logic              finishb,
    output logic              readya,
    output logic [DATA_W-1:0] doutb,
    output logic              readyb
`ifdef PINGPONG_RAM_ERR_EN
    ,
    output logic              err_wr,
    output logic              err_rd
`endif
);

    logic [NUM_BANKS-1:0] full_q, full_d;
    bank_sel_t            wr_sel_q, wr_sel_d;
    bank_sel_t            rd_sel_q, rd_sel_d;
    // Bank that was read last cycle; selects which bank's read register drives doutb.
    bank_sel_t            rd_sel_dly_q;

    logic                 wr_ok;
    logic                 commit;
    logic                 release_b;
    logic [DATA_W-1:0]    rdata [NUM_BANKS];

    assign readya    = ~full_q[wr_sel_q];
    assign readyb    = full_q[rd_sel_q];
    assign wr_ok     = wea & readya;
    assign commit    = finisha & readya;
    assign release_b = finishb & readyb;

    // Commit and release never target the same bank: with equal selects the
    // bank is either full (A blocked) or empty (B blocked).
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (commit) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = other_bank(wr_sel_q);
        end
        if (release_b) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = other_bank(rd_sel_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q       <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            rd_sel_dly_q <= 1'b0;
        end else begin
            full_q       <= full_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            rd_sel_dly_q <= rd_sel_q;
        end
    end

    // Both banks read addrb every cycle; the delayed select picks the one that
    // was the read bank when the address was presented.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        pingpong_ram_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we_i    (wr_ok & (wr_sel_q == bank_sel_t'(b))),
            .waddr_i (addra),
            .wdata_i (dina),
            .raddr_i (addrb),
            .rdata_o (rdata[b])
        );
    end

    assign doutb = rdata[rd_sel_dly_q];

`ifdef PINGPONG_RAM_ERR_EN
    logic err_wr_q, err_wr_d;
    logic err_rd_q, err_rd_d;

    always_comb begin
        err_wr_d = err_wr_q | ((wea | finisha) & ~readya);
        err_rd_d = err_rd_q | (finishb & ~readyb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_wr_q <= 1'b0;
            err_rd_q <= 1'b0;
        end else begin
            err_wr_q <= err_wr_d;
            err_rd_q <= err_rd_d;
        end
    end

    assign err_wr = err_wr_q;
    assign err_rd = err_rd_q;
`endif

endmodule

// File: tb/tb_pingpong_ram.sv
module tb_pingpong_ram;

    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addra = '0;
    logic          wea = 1'b0;
    logic [DW-1:0] dina = '0;
    logic          finisha = 1'b0;
    logic [AW-1:0] addrb = '0;
    logic          finishb = 1'b0;
    logic          readya;
    logic [DW-1:0] doutb;
    logic          readyb;
`ifdef PINGPONG_RAM_ERR_EN
    logic          err_wr;
    logic          err_rd;
`endif

    pingpong_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .addra   (addra),
        .wea     (wea),
        .dina    (dina),
        .finisha (finisha),
        .addrb   (addrb),
        .finishb (finishb),
        .readya  (readya),
        .doutb   (doutb),
        .readyb  (readyb)
`ifdef PINGPONG_RAM_ERR_EN
        ,
        .err_wr  (err_wr),
        .err_rd  (err_rd)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bank contents plus an occupancy view of the store.
    // rd_bank is the bank the consumer drains; cnt is how many completed
    // frames are waiting (0..2); the producer's bank follows them.
    logic [DW-1:0] m   [2][DEPTH];
    bit            vld [2][DEPTH];
    int            rd_bank = 0;
    int            cnt = 0;
    logic [DW-1:0] exp_dout = '0;
    bit            exp_dout_vld = 1'b1;
    bit            m_err_wr = 1'b0;
    bit            m_err_rd = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        rd_bank      = 0;
        cnt          = 0;
        exp_dout     = '0;
        exp_dout_vld = 1'b1;
        m_err_wr     = 1'b0;
        m_err_rd     = 1'b0;
    endtask

    task automatic check_outputs();
        check_val("readya", {31'd0, readya}, {31'd0, cnt < 2});
        check_val("readyb", {31'd0, readyb}, {31'd0, cnt > 0});
        if (exp_dout_vld) check_val("doutb", {16'd0, doutb}, {16'd0, exp_dout});
`ifdef PINGPONG_RAM_ERR_EN
        check_val("err_wr", {31'd0, err_wr}, {31'd0, m_err_wr});
        check_val("err_rd", {31'd0, err_rd}, {31'd0, m_err_rd});
`endif
    endtask

    task automatic cycle(input logic we, input logic [AW-1:0] aa, input logic [DW-1:0] d,
                         input logic fa, input logic [AW-1:0] ab, input logic fb);
        bit rdy_a, rdy_b;
        int wb;
        @(negedge clk);
        wea = we; addra = aa; dina = d; finisha = fa; addrb = ab; finishb = fb;
        @(posedge clk);
        rdy_a = (cnt < 2);
        rdy_b = (cnt > 0);
        wb    = (rd_bank + cnt) % 2;
        exp_dout     = m[rd_bank][ab];
        exp_dout_vld = vld[rd_bank][ab];
        if ((we || fa) && !rdy_a) m_err_wr = 1'b1;
        if (fb && !rdy_b)         m_err_rd = 1'b1;
        if (we && rdy_a) begin
            m[wb][aa]   = d;
            vld[wb][aa] = 1'b1;
        end
        if (fa && rdy_a) cnt++;
        if (fb && rdy_b) begin
            cnt--;
            rd_bank = 1 - rd_bank;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic [AW-1:0] ab);
        cycle(1'b0, '0, '0, 1'b0, ab, 1'b0);
    endtask

    task automatic write_frame(input int base, input bit with_finish);
        for (int i = 0; i < 64; i++) cycle(1'b1, AW'(i), DW'(i + base), 1'b0, '0, 1'b0);
        if (with_finish) cycle(1'b0, '0, '0, 1'b1, '0, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_readya", {31'd0, readya}, 32'd1);
        check_val("rst_readyb", {31'd0, readyb}, 32'd0);
        check_val("rst_doutb", {16'd0, doutb}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) begin
                m[b][a]   = '0;
                vld[b][a] = 1'b0;
            end
        model_reset();
        #1;
        check_val("init_readya", {31'd0, readya}, 32'd1);
        check_val("init_readyb", {31'd0, readyb}, 32'd0);
        check_val("init_doutb", {16'd0, doutb}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First frame, then read it back.
        write_frame(0, 1'b1);
        check_val("f1_readya", {31'd0, readya}, 32'd1);
        check_val("f1_readyb", {31'd0, readyb}, 32'd1);
        idle(7'd5);
        check_val("f1_rd5", {16'd0, doutb}, 32'd5);

        // Second frame fills the store; third is dropped.
        write_frame(100, 1'b1);
        check_val("full_readya", {31'd0, readya}, 32'd0);
        write_frame(999, 1'b1);
        idle(7'd10);
        check_val("ovf_rd10", {16'd0, doutb}, 32'd10);
`ifdef PINGPONG_RAM_ERR_EN
        check_val("err_wr_set", {31'd0, err_wr}, 32'd1);
`endif

        // Drain both frames.
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
        check_val("rel1_readyb", {31'd0, readyb}, 32'd1);
        check_val("rel1_readya", {31'd0, readya}, 32'd1);
        idle(7'd10);
        check_val("b1_rd10", {16'd0, doutb}, 32'd110);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
        check_val("rel2_readyb", {31'd0, readyb}, 32'd0);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
`ifdef PINGPONG_RAM_ERR_EN
        check_val("err_rd_set", {31'd0, err_rd}, 32'd1);
        check_val("err_wr_hold", {31'd0, err_wr}, 32'd1);
`endif

        // Simultaneous commit and release.
        write_frame(200, 1'b1);
        write_frame(300, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, '0, 1'b1);
        check_val("swap_readya", {31'd0, readya}, 32'd1);
        check_val("swap_readyb", {31'd0, readyb}, 32'd1);
        idle(7'd10);
        check_val("swap_rd10", {16'd0, doutb}, 32'd310);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) cycle(1'b1, AW'(i), DW'(i + 500), 1'b0, '0, 1'b0);
        async_reset();
`ifdef PINGPONG_RAM_ERR_EN
        check_val("rst_err_wr", {31'd0, err_wr}, 32'd0);
        check_val("rst_err_rd", {31'd0, err_rd}, 32'd0);
`endif
        idle('0);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            if (n == 400) async_reset();
            cycle(1'($urandom_range(0, 3) != 0), AW'($urandom), DW'($urandom),
                  1'($urandom_range(0, 15) == 0), AW'($urandom),
                  1'($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
